procyon_ccu_arb: RTL and testbench
==================================

Name: procyon_ccu_arb

Overview:
- Arbiter that shares the single CCU memory port between multiple cacheline-granular requesters, e.g. the MHQ fill read (index 0) and the victim-queue writeback (index 1).
- Requesters hold a level request (en/we/len/addr/data) until they see their done pulse.
- The arbiter grants one requester at a time with round-robin priority and latches its request.
- It drives the downstream CCU bus and routes done/data back to the granted requester only.

Parameters:
OPTN_CCU_ARB_DEPTH, 2, number of requesters (≥1)
OPTN_ADDR_WIDTH, 32, address width
OPTN_DC_LINE_SIZE, 1024, cacheline bytes; DC_LINE_WIDTH = OPTN_DC_LINE_SIZE*8
CCU_ARB_IDX_WIDTH, derived, OPTN_CCU_ARB_DEPTH==1 ? 1 : $clog2(OPTN_CCU_ARB_DEPTH)

Ports:
clk  in  1  clock; all state updates on rising edge
n_rst  in  1  reset, synchronous, active-high (1 = reset)
i_ccu_arb_valid  in  DEPTH  per-requester request level
i_ccu_arb_we  in  DEPTH  per-requester write enable
i_ccu_arb_len  in  DEPTH*`PCYN_CCU_LEN_WIDTH  per-requester length, packed, requester i at [i*W +: W]
i_ccu_arb_addr  in  DEPTH*OPTN_ADDR_WIDTH  per-requester address, packed
i_ccu_arb_data  in  DEPTH*DC_LINE_WIDTH  per-requester write data, packed
o_ccu_arb_done  out  DEPTH  one-hot done pulse to the granted requester
o_ccu_arb_data  out  DC_LINE_WIDTH  read data, valid with done
o_ccu_en  out  1  bus request
o_ccu_we  out  1  bus write
o_ccu_len  out  `PCYN_CCU_LEN_WIDTH  bus length
o_ccu_addr  out  OPTN_ADDR_WIDTH  bus address
o_ccu_data  out  DC_LINE_WIDTH  bus write data
i_ccu_done  in  1  bus completion pulse
i_ccu_data  in  DC_LINE_WIDTH  bus read data, valid with i_ccu_done

Behaviour:

FSM has two states: IDLE and BUSY.

IDLE:
- If any i_ccu_arb_valid bit is set, select the winner by round-robin.
- On the next edge: latch the winner's we/len/addr/data into registers, register grant_idx, go to BUSY.
- With no request, stay in IDLE.

BUSY:
- o_ccu_en=1; o_ccu_we/len/addr/data come from the latched registers.
- Later changes on requester inputs are ignored until done.
- When i_ccu_done=1:
  - o_ccu_arb_done[grant_idx]=1 in the same cycle (combinational); all other done bits are 0.
  - o_ccu_arb_data=i_ccu_data.
  - Next state is IDLE; rr_ptr <= grant_idx+1, wrapping DEPTH-1→0.

Round-robin:
- The winner is the lowest index ≥ rr_ptr with valid set, else the lowest index < rr_ptr with valid set.
- rr_ptr resets to 0.
- With DEPTH=1, the requester always wins and rr_ptr stays 0.

Latency and handshake:
- Request visible in cycle N (IDLE) → o_ccu_en=1 in cycle N+1.
- Done in cycle M → IDLE in M+1 → next o_ccu_en no earlier than M+2.
- There is therefore exactly one dead cycle between transactions.
- Requesters must deassert valid in the cycle after their done, or present a new request. The IDLE cycle samples the requester inputs from that cycle.
- A requester dropping valid while granted is illegal. The bench asserts it must not happen; the arbiter completes the transaction regardless.

Idle and reset values:
- o_ccu_arb_data is don't-care when no done is asserted; drive i_ccu_data unconditionally.
- On n_rst: state=IDLE, rr_ptr=0, grant_idx=0, latched registers=0.
- Outputs during reset: o_ccu_en=0, o_ccu_arb_done=0, o_ccu_we=0, o_ccu_len=0, o_ccu_addr=0, o_ccu_data=0.

Boundary cases:
- Reset while BUSY aborts the grant. An i_ccu_done arriving during or after reset while IDLE produces no o_ccu_arb_done.
- i_ccu_done while IDLE is ignored.
- Done plus a new request in the same cycle: the request is sampled in the IDLE cycle that follows, not in the done cycle.
- rr_ptr update uses the current grant_idx even when grant_idx = DEPTH-1 (wraps to 0).

Test Plan:
1. Single request: reset, then req0 valid (we=0, addr=0x1000) at cycle 2 → o_ccu_en=1, addr=0x1000 at cycle 3. Done at cycle 6 → o_ccu_arb_done=2'b01 and data forwarded at cycle 6; o_ccu_en=0 at cycle 7.
2. Contention: req0 and req1 both valid from reset → grants go 0,1,0,1 across four transactions, each requester re-requesting immediately; done only ever goes to the granted index.
3. Latching: req1 write (addr=0x2000, data=0xA5…) granted, then its addr changes to 0x3000 while BUSY → o_ccu_addr stays 0x2000 until done.
4. Back-to-back: req0 alone, re-requests in the cycle after done → exactly one dead cycle with o_ccu_en=0 between transactions; rr_ptr wrap does not block it.
5. Reset mid-op: n_rst asserted while BUSY, i_ccu_done pulsed during reset and in the next cycle → o_ccu_en=0, no done bits; the first post-reset grant goes to index 0 when both request.
6. Spurious done: i_ccu_done=1 in IDLE with no requests → no o_ccu_arb_done and state stays IDLE.

Source files
------------

// File: rtl/procyon_ccu_arb_if.sv
// Signal bundle between the cacheline requesters, the CCU arbiter and the CCU memory port.
// The slave modport is the arbiter's view; the master modport is the view of everything around it.
`ifndef PCYN_CCU_LEN_WIDTH
`define PCYN_CCU_LEN_WIDTH 4
`endif

interface procyon_ccu_arb_if #(
    parameter int OPTN_CCU_ARB_DEPTH = 2,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_DC_LINE_SIZE  = 1024
);
    localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8;
    localparam int LEN_W         = `PCYN_CCU_LEN_WIDTH;

    logic [OPTN_CCU_ARB_DEPTH-1:0]                 i_ccu_arb_valid;
    logic [OPTN_CCU_ARB_DEPTH-1:0]                 i_ccu_arb_we;
    logic [OPTN_CCU_ARB_DEPTH*LEN_W-1:0]           i_ccu_arb_len;
    logic [OPTN_CCU_ARB_DEPTH*OPTN_ADDR_WIDTH-1:0] i_ccu_arb_addr;
    logic [OPTN_CCU_ARB_DEPTH*DC_LINE_WIDTH-1:0]   i_ccu_arb_data;
    logic [OPTN_CCU_ARB_DEPTH-1:0]                 o_ccu_arb_done;
    logic [DC_LINE_WIDTH-1:0]                      o_ccu_arb_data;
    logic                                          o_ccu_en;
    logic                                          o_ccu_we;
    logic [LEN_W-1:0]                              o_ccu_len;
    logic [OPTN_ADDR_WIDTH-1:0]                    o_ccu_addr;
    logic [DC_LINE_WIDTH-1:0]                      o_ccu_data;
    logic                                          i_ccu_done;
    logic [DC_LINE_WIDTH-1:0]                      i_ccu_data;

    modport slave (
        input  i_ccu_arb_valid, i_ccu_arb_we, i_ccu_arb_len, i_ccu_arb_addr, i_ccu_arb_data,
        input  i_ccu_done, i_ccu_data,
        output o_ccu_arb_done, o_ccu_arb_data,
        output o_ccu_en, o_ccu_we, o_ccu_len, o_ccu_addr, o_ccu_data
    );

    modport master (
        output i_ccu_arb_valid, i_ccu_arb_we, i_ccu_arb_len, i_ccu_arb_addr, i_ccu_arb_data,
        output i_ccu_done, i_ccu_data,
        input  o_ccu_arb_done, o_ccu_arb_data,
        input  o_ccu_en, o_ccu_we, o_ccu_len, o_ccu_addr, o_ccu_data
    );
endinterface

// File: rtl/procyon_ccu_arb.sv
// Round-robin arbiter sharing the single CCU memory port between cacheline requesters.
// One transaction at a time; the winner's request is latched so requester-side changes are ignored while busy.
`ifndef PCYN_CCU_LEN_WIDTH
`define PCYN_CCU_LEN_WIDTH 4
`endif

module procyon_ccu_arb #(
    parameter int OPTN_CCU_ARB_DEPTH = 2,
    parameter int OPTN_ADDR_WIDTH    = 32,
    parameter int OPTN_DC_LINE_SIZE  = 1024
) (
    input  logic                    clk,
    input  logic                    n_rst,
    procyon_ccu_arb_if.slave        arb_if
);
    localparam int DC_LINE_WIDTH = OPTN_DC_LINE_SIZE * 8;
    localparam int LEN_W         = `PCYN_CCU_LEN_WIDTH;
    localparam int IDX_W         = (OPTN_CCU_ARB_DEPTH == 1) ? 1 : $clog2(OPTN_CCU_ARB_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;
    logic                       we_q, we_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [OPTN_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DC_LINE_WIDTH-1:0]   data_q, data_d;

    logic [IDX_W-1:0]           win_idx_s;
    logic                       win_found_s;
    logic [IDX_W:0]             cand_s;
    logic [OPTN_CCU_ARB_DEPTH-1:0] done_s;

    // Round-robin winner: first valid requester scanning upward from rr_ptr, wrapping past DEPTH-1.
    always_comb begin
        win_idx_s   = '0;
        win_found_s = 1'b0;
        cand_s      = '0;
        for (int i = 0; i < OPTN_CCU_ARB_DEPTH; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand_s >= (IDX_W+1)'(OPTN_CCU_ARB_DEPTH)) begin
                cand_s = cand_s - (IDX_W+1)'(OPTN_CCU_ARB_DEPTH);
            end else begin
                cand_s = cand_s;
            end
            if (!win_found_s && arb_if.i_ccu_arb_valid[cand_s[IDX_W-1:0]]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IDX_W-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state logic: latch the winner in IDLE, release and advance the pointer on bus completion.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        we_d        = we_q;
        len_d       = len_q;
        addr_d      = addr_q;
        data_d      = data_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_d     = ST_BUSY;
                    grant_idx_d = win_idx_s;
                    we_d        = arb_if.i_ccu_arb_we[win_idx_s];
                    len_d       = arb_if.i_ccu_arb_len[int'(win_idx_s)*LEN_W +: LEN_W];
                    addr_d      = arb_if.i_ccu_arb_addr[int'(win_idx_s)*OPTN_ADDR_WIDTH +: OPTN_ADDR_WIDTH];
                    data_d      = arb_if.i_ccu_arb_data[int'(win_idx_s)*DC_LINE_WIDTH +: DC_LINE_WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (arb_if.i_ccu_done) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_idx_q == IDX_W'(OPTN_CCU_ARB_DEPTH-1)) ? '0 : grant_idx_q + IDX_W'(1);
                end else begin
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            we_q        <= 1'b0;
            len_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            we_q        <= we_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // Completion routed only to the granted requester; suppressed while reset is held.
    always_comb begin
        done_s = '0;
        if ((state_q == ST_BUSY) && arb_if.i_ccu_done && !n_rst) begin
            done_s[grant_idx_q] = 1'b1;
        end else begin
            done_s = '0;
        end
    end

    assign arb_if.o_ccu_arb_done = done_s;
    assign arb_if.o_ccu_arb_data = arb_if.i_ccu_data;
    assign arb_if.o_ccu_en       = (state_q == ST_BUSY) && !n_rst;
    assign arb_if.o_ccu_we       = we_q;
    assign arb_if.o_ccu_len      = len_q;
    assign arb_if.o_ccu_addr     = addr_q;
    assign arb_if.o_ccu_data     = data_q;

endmodule

// File: tb/tb_procyon_ccu_arb.sv
// Self-checking bench for procyon_ccu_arb: directed scenarios plus randomized traffic against a cycle model.
`ifndef PCYN_CCU_LEN_WIDTH
`define PCYN_CCU_LEN_WIDTH 4
`endif

module tb_procyon_ccu_arb;
    localparam int DEPTH = 2;
    localparam int AW    = 32;
    localparam int LS    = 16;
    localparam int DW    = LS * 8;
    localparam int LW    = `PCYN_CCU_LEN_WIDTH;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    procyon_ccu_arb_if #(.OPTN_CCU_ARB_DEPTH(DEPTH), .OPTN_ADDR_WIDTH(AW), .OPTN_DC_LINE_SIZE(LS)) bus ();

    procyon_ccu_arb #(.OPTN_CCU_ARB_DEPTH(DEPTH), .OPTN_ADDR_WIDTH(AW), .OPTN_DC_LINE_SIZE(LS)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding grant, round-robin from the requester after the last one served.
    bit            m_busy = 1'b0;
    int            m_grant = 0;
    int            m_ptr = 0;
    int            mw, mc;
    logic          m_we = 1'b0;
    logic [LW-1:0] m_len = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;

    always @(posedge clk) begin
        if (n_rst) begin
            m_busy = 1'b0; m_ptr = 0; m_grant = 0;
            m_we = 1'b0; m_len = '0; m_addr = '0; m_data = '0;
        end else if (m_busy) begin
            if (bus.i_ccu_done) begin
                m_busy = 1'b0;
                m_ptr  = (m_grant + 1) % DEPTH;
            end
        end else begin
            mw = -1;
            for (int k = 0; k < DEPTH; k++) begin
                mc = (m_ptr + k) % DEPTH;
                if (mw < 0 && bus.i_ccu_arb_valid[mc]) mw = mc;
            end
            if (mw >= 0) begin
                m_busy  = 1'b1;
                m_grant = mw;
                m_we    = bus.i_ccu_arb_we[mw];
                m_len   = bus.i_ccu_arb_len[mw*LW +: LW];
                m_addr  = bus.i_ccu_arb_addr[mw*AW +: AW];
                m_data  = bus.i_ccu_arb_data[mw*DW +: DW];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_ccu_arb_valid = '0;
        bus.i_ccu_arb_we    = '0;
        bus.i_ccu_arb_len   = '0;
        bus.i_ccu_arb_addr  = '0;
        bus.i_ccu_arb_data  = '0;
        bus.i_ccu_done      = 1'b0;
        bus.i_ccu_data      = '0;
    endtask

    task automatic do_reset();
        tick();
        n_rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        n_rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic test_reset();
        clear_inputs();
        n_rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks += 6;
        if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b want 0", bus.o_ccu_en); end
        if (bus.o_ccu_arb_done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b want 00", bus.o_ccu_arb_done); end
        if (bus.o_ccu_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", bus.o_ccu_we); end
        if (bus.o_ccu_len !== '0) begin errors++; $display("FAIL reset_len: got %0h want 0", bus.o_ccu_len); end
        if (bus.o_ccu_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.o_ccu_addr); end
        if (bus.o_ccu_data !== '0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.o_ccu_data); end
    endtask

    task automatic test_single();
        logic [DW-1:0] rd;
        do_reset();
        bus.i_ccu_arb_valid = 2'b01;
        bus.i_ccu_arb_we[0] = 1'b0;
        bus.i_ccu_arb_addr[0 +: AW] = 32'h0000_1000;
        bus.i_ccu_arb_len[0 +: LW] = 4'h3;
        @(negedge clk);
        checks++;
        if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL single_idle_en: got %0b want 0", bus.o_ccu_en); end
        tick();
        @(negedge clk);
        checks += 4;
        if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL single_en: got %0b want 1", bus.o_ccu_en); end
        if (bus.o_ccu_addr !== 32'h0000_1000) begin errors++; $display("FAIL single_addr: got %0h want 1000", bus.o_ccu_addr); end
        if (bus.o_ccu_we !== 1'b0) begin errors++; $display("FAIL single_we: got %0b want 0", bus.o_ccu_we); end
        if (bus.o_ccu_len !== 4'h3) begin errors++; $display("FAIL single_len: got %0h want 3", bus.o_ccu_len); end
        tick();
        tick();
        tick();
        rd = rand_line();
        bus.i_ccu_done = 1'b1;
        bus.i_ccu_data = rd;
        @(negedge clk);
        checks += 3;
        if (bus.o_ccu_arb_done !== 2'b01) begin errors++; $display("FAIL single_done: got %b want 01", bus.o_ccu_arb_done); end
        if (bus.o_ccu_arb_data !== rd) begin errors++; $display("FAIL single_rdata: got %0h want %0h", bus.o_ccu_arb_data, rd); end
        if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL single_en_at_done: got %0b want 1", bus.o_ccu_en); end
        tick();
        bus.i_ccu_done = 1'b0;
        bus.i_ccu_arb_valid = 2'b00;
        @(negedge clk);
        checks += 2;
        if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL single_en_after: got %0b want 0", bus.o_ccu_en); end
        if (bus.o_ccu_arb_done !== 2'b00) begin errors++; $display("FAIL single_done_after: got %b want 00", bus.o_ccu_arb_done); end
    endtask

    task automatic test_contention();
        logic [1:0]    exp_done;
        logic [AW-1:0] exp_addr;
        do_reset();
        bus.i_ccu_arb_valid = 2'b11;
        bus.i_ccu_arb_addr[0 +: AW]  = 32'h0000_0100;
        bus.i_ccu_arb_addr[AW +: AW] = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            exp_done = 2'b01 << (t % 2);
            exp_addr = ((t % 2) == 1) ? 32'h0000_0200 : 32'h0000_0100;
            @(negedge clk);
            checks++;
            if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL cont_idle_en[%0d]: got %0b want 0", t, bus.o_ccu_en); end
            tick();
            @(negedge clk);
            checks += 3;
            if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL cont_en[%0d]: got %0b want 1", t, bus.o_ccu_en); end
            if (bus.o_ccu_addr !== exp_addr) begin errors++; $display("FAIL cont_addr[%0d]: got %0h want %0h", t, bus.o_ccu_addr, exp_addr); end
            if (bus.o_ccu_arb_done !== 2'b00) begin errors++; $display("FAIL cont_early_done[%0d]: got %b want 00", t, bus.o_ccu_arb_done); end
            tick();
            bus.i_ccu_done = 1'b1;
            bus.i_ccu_data = rand_line();
            @(negedge clk);
            checks++;
            if (bus.o_ccu_arb_done !== exp_done) begin errors++; $display("FAIL cont_done[%0d]: got %b want %b", t, bus.o_ccu_arb_done, exp_done); end
            tick();
            bus.i_ccu_done = 1'b0;
        end
        bus.i_ccu_arb_valid = 2'b00;
    endtask

    task automatic test_latching();
        logic [DW-1:0] a5;
        a5 = {LS{8'hA5}};
        do_reset();
        bus.i_ccu_arb_valid = 2'b10;
        bus.i_ccu_arb_we[1] = 1'b1;
        bus.i_ccu_arb_len[LW +: LW] = 4'hF;
        bus.i_ccu_arb_addr[AW +: AW] = 32'h0000_2000;
        bus.i_ccu_arb_data[DW +: DW] = a5;
        tick();
        bus.i_ccu_arb_addr[AW +: AW] = 32'h0000_3000;
        bus.i_ccu_arb_data[DW +: DW] = ~a5;
        bus.i_ccu_arb_we[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks += 4;
            if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL latch_en[%0d]: got %0b want 1", k, bus.o_ccu_en); end
            if (bus.o_ccu_addr !== 32'h0000_2000) begin errors++; $display("FAIL latch_addr[%0d]: got %0h want 2000", k, bus.o_ccu_addr); end
            if (bus.o_ccu_data !== a5) begin errors++; $display("FAIL latch_data[%0d]: got %0h want %0h", k, bus.o_ccu_data, a5); end
            if (bus.o_ccu_we !== 1'b1) begin errors++; $display("FAIL latch_we[%0d]: got %0b want 1", k, bus.o_ccu_we); end
            tick();
        end
        bus.i_ccu_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ccu_arb_done !== 2'b10) begin errors++; $display("FAIL latch_done: got %b want 10", bus.o_ccu_arb_done); end
        tick();
        bus.i_ccu_done = 1'b0;
        bus.i_ccu_arb_valid = 2'b00;
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.i_ccu_arb_valid = 2'b01;
        bus.i_ccu_arb_addr[0 +: AW] = 32'h0000_0400;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL b2b_dead_en[%0d]: got %0b want 0", t, bus.o_ccu_en); end
            tick();
            bus.i_ccu_done = 1'b1;
            @(negedge clk);
            checks += 2;
            if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL b2b_en[%0d]: got %0b want 1", t, bus.o_ccu_en); end
            if (bus.o_ccu_arb_done !== 2'b01) begin errors++; $display("FAIL b2b_done[%0d]: got %b want 01", t, bus.o_ccu_arb_done); end
            tick();
            bus.i_ccu_done = 1'b0;
        end
        bus.i_ccu_arb_valid = 2'b00;
    endtask

    task automatic test_reset_midop();
        do_reset();
        bus.i_ccu_arb_valid = 2'b01;
        bus.i_ccu_arb_addr[0 +: AW]  = 32'h0000_0500;
        bus.i_ccu_arb_addr[AW +: AW] = 32'h0000_0600;
        tick();
        bus.i_ccu_done = 1'b1;
        tick();
        bus.i_ccu_done = 1'b0;
        bus.i_ccu_arb_valid = 2'b11;
        tick();
        @(negedge clk);
        checks += 2;
        if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL midop_busy_en: got %0b want 1", bus.o_ccu_en); end
        if (bus.o_ccu_addr !== 32'h0000_0600) begin errors++; $display("FAIL midop_busy_addr: got %0h want 600", bus.o_ccu_addr); end
        tick();
        n_rst = 1'b1;
        bus.i_ccu_done = 1'b1;
        @(negedge clk);
        checks += 2;
        if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL midop_rst_en: got %0b want 0", bus.o_ccu_en); end
        if (bus.o_ccu_arb_done !== 2'b00) begin errors++; $display("FAIL midop_rst_done: got %b want 00", bus.o_ccu_arb_done); end
        tick();
        n_rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL midop_post_en: got %0b want 0", bus.o_ccu_en); end
        if (bus.o_ccu_arb_done !== 2'b00) begin errors++; $display("FAIL midop_post_done: got %b want 00", bus.o_ccu_arb_done); end
        tick();
        bus.i_ccu_done = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL midop_regrant_en: got %0b want 1", bus.o_ccu_en); end
        if (bus.o_ccu_addr !== 32'h0000_0500) begin errors++; $display("FAIL midop_regrant_addr: got %0h want 500", bus.o_ccu_addr); end
        tick();
        bus.i_ccu_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ccu_arb_done !== 2'b01) begin errors++; $display("FAIL midop_regrant_done: got %b want 01", bus.o_ccu_arb_done); end
        tick();
        bus.i_ccu_done = 1'b0;
        bus.i_ccu_arb_valid = 2'b00;
    endtask

    task automatic test_spurious_done();
        do_reset();
        bus.i_ccu_done = 1'b1;
        bus.i_ccu_data = rand_line();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks += 2;
            if (bus.o_ccu_arb_done !== 2'b00) begin errors++; $display("FAIL spur_done[%0d]: got %b want 00", k, bus.o_ccu_arb_done); end
            if (bus.o_ccu_en !== 1'b0) begin errors++; $display("FAIL spur_en[%0d]: got %0b want 0", k, bus.o_ccu_en); end
            tick();
        end
        bus.i_ccu_done = 1'b0;
        bus.i_ccu_arb_valid = 2'b10;
        tick();
        @(negedge clk);
        checks++;
        if (bus.o_ccu_en !== 1'b1) begin errors++; $display("FAIL spur_idle_grant_en: got %0b want 1", bus.o_ccu_en); end
        tick();
        bus.i_ccu_done = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_ccu_arb_done !== 2'b10) begin errors++; $display("FAIL spur_idle_grant_done: got %b want 10", bus.o_ccu_arb_done); end
        tick();
        bus.i_ccu_done = 1'b0;
        bus.i_ccu_arb_valid = 2'b00;
    endtask

    task automatic test_random();
        logic [DEPTH-1:0] got_done;
        logic [DEPTH-1:0] exp_done;
        logic [DW-1:0]    rd;
        got_done = '0;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (got_done[i] || (!bus.i_ccu_arb_valid[i] && $urandom_range(0, 3) == 0)) begin
                    bus.i_ccu_arb_valid[i] = got_done[i] ? 1'($urandom_range(0, 1)) : 1'b1;
                    bus.i_ccu_arb_we[i] = 1'($urandom_range(0, 1));
                    bus.i_ccu_arb_len[i*LW +: LW] = LW'($urandom_range(0, 15));
                    bus.i_ccu_arb_addr[i*AW +: AW] = $urandom;
                    bus.i_ccu_arb_data[i*DW +: DW] = rand_line();
                end
            end
            rd = rand_line();
            bus.i_ccu_data = rd;
            bus.i_ccu_done = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            @(negedge clk);
            exp_done = (m_busy && bus.i_ccu_done) ? DEPTH'(1 << m_grant) : '0;
            checks += 2;
            if (bus.o_ccu_en !== m_busy) begin errors++; $display("FAIL rnd_en@%0d: got %0b want %0b", cyc, bus.o_ccu_en, m_busy); end
            if (bus.o_ccu_arb_done !== exp_done) begin errors++; $display("FAIL rnd_done@%0d: got %b want %b", cyc, bus.o_ccu_arb_done, exp_done); end
            if (m_busy) begin
                checks += 4;
                if (bus.o_ccu_we !== m_we) begin errors++; $display("FAIL rnd_we@%0d: got %0b want %0b", cyc, bus.o_ccu_we, m_we); end
                if (bus.o_ccu_len !== m_len) begin errors++; $display("FAIL rnd_len@%0d: got %0h want %0h", cyc, bus.o_ccu_len, m_len); end
                if (bus.o_ccu_addr !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %0h want %0h", cyc, bus.o_ccu_addr, m_addr); end
                if (bus.o_ccu_data !== m_data) begin errors++; $display("FAIL rnd_wdata@%0d: got %0h want %0h", cyc, bus.o_ccu_data, m_data); end
            end
            if (exp_done != '0) begin
                checks++;
                if (bus.o_ccu_arb_data !== rd) begin errors++; $display("FAIL rnd_rdata@%0d: got %0h want %0h", cyc, bus.o_ccu_arb_data, rd); end
            end
            got_done = exp_done;
            tick();
        end
        bus.i_ccu_done = 1'b0;
        bus.i_ccu_arb_valid = '0;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_latching();
        test_back_to_back();
        test_reset_midop();
        test_spurious_done();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
